instr_prefetch: RTL

//  Parametrised instruction fetch unit with a prefetch queue; successor to the fixed 6-bit fetch path.

---
 rtl/instr_prefetch_if.sv | 49 ++++
 rtl/instr_prefetch.sv | 117 +++++++++++
 2 files changed

// File: rtl/instr_prefetch_if.sv
// -----------------------------------------------------------------------------
// instr_prefetch_if
//   Groups the instruction-memory read port and the consumer-side fetch
//   handshake of the instruction prefetch unit into one bundle.
//
//   slave  : the prefetch unit (drives mem_addr/mem_rd and the queue head)
//   master : the surrounding system (memory + processor)
//
//   run          fetch enable (0 = issue no new reads, queue still drains)
//   mem_addr     read address to instruction memory
//   mem_rd       read strobe; mem_data is valid the following cycle
//   mem_data     read data from instruction memory
//   instr        word at the queue head
//   instr_pc     address of the queue-head word
//   instr_valid  queue not empty
//   instr_ready  consumer accepts the head this cycle
//   redirect     flush queue and restart fetch at redirect_pc
//   redirect_pc  new fetch address
//   count        current queue occupancy
// -----------------------------------------------------------------------------
interface instr_prefetch_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              run;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  run, mem_data, instr_ready, redirect, redirect_pc,
        output mem_addr, mem_rd, instr, instr_pc, instr_valid, count
    );

    modport master (
        output run, mem_data, instr_ready, redirect, redirect_pc,
        input  mem_addr, mem_rd, instr, instr_pc, instr_valid, count
    );
endinterface

// File: rtl/instr_prefetch.sv
// -----------------------------------------------------------------------------
// instr_prefetch
//   Instruction fetch unit with a DEPTH-entry prefetch queue. Streams words
//   from a synchronous instruction memory (1-cycle read latency) into the
//   queue; the processor pops them through a valid/ready handshake. A redirect
//   flushes the queue (including any in-flight return) and restarts fetch.
//
//   clk   single clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   bus   instr_prefetch_if.slave: memory read port, consumer handshake,
//         redirect request and occupancy count
// -----------------------------------------------------------------------------
module instr_prefetch #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 6,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    instr_prefetch_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Queue storage (data path, not reset)
    logic [DATA_W-1:0] qdata_q [DEPTH];
    logic [ADDR_W-1:0] qpc_q   [DEPTH];

    // Control state
    logic [ADDR_W-1:0] pc_q,       pc_d;
    logic [ADDR_W-1:0] tag_pc_q,   tag_pc_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;

    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    occ_after;

    always_comb begin
        // A redirect flushes the queue, so a same-cycle pop request is dropped.
        pop  = (count_q != '0) & bus.instr_ready & ~bus.redirect;
        push = inflight_q & ~bus.redirect & ~rst;

        // Space reservation: the in-flight word already owns a slot, so a new
        // read only goes out if the queue cannot overflow when it returns.
        occ_after = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
        issue     = bus.run & ~bus.redirect & ~rst & (occ_after < (CNT_W+1)'(DEPTH));

        pc_d       = pc_q;
        tag_pc_d   = tag_pc_q;
        inflight_d = 1'b0;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (bus.redirect) begin
            pc_d     = bus.redirect_pc;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (issue) begin
                pc_d       = pc_q + ADDR_W'(1);
                tag_pc_d   = pc_q;
                inflight_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
        tag_pc_q <= tag_pc_d;
    end

    // Return stage: memory data from last cycle's read lands in the queue
    always_ff @(posedge clk) begin
        if (push) begin
            qdata_q[wr_ptr_q] <= bus.mem_data;
            qpc_q[wr_ptr_q]   <= tag_pc_q;
        end
    end

    // Head outputs come only from registered queue state
    assign bus.mem_rd      = issue;
    assign bus.mem_addr    = pc_q;
    assign bus.instr       = qdata_q[rd_ptr_q];
    assign bus.instr_pc    = qpc_q[rd_ptr_q];
    assign bus.instr_valid = (count_q != '0);
    assign bus.count       = count_q;
endmodule
